// File: rtl/hazard_forward_ctrl.sv
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : RV32I EX/MEM/WB destination scoreboard producing registered
//               forward selects, load-use stall/bubble and a bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_forward_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_rd,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              mem_hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [1:0]        fwd_sel_rs1,
    output logic [1:0]        fwd_sel_rs2,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [1:0]       c_SEL_RF  = 2'd0;
    localparam logic [1:0]       c_SEL_EX  = 2'd1;
    localparam logic [1:0]       c_SEL_MEM = 2'd2;
    localparam logic [1:0]       c_SEL_WB  = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Scoreboard slots: {valid, rd, wr, is_load} per stage.
    logic              r_ex_v,  r_mem_v,  r_wb_v;
    logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic              r_ex_wr, r_mem_wr, r_wb_wr;
    logic              r_ex_ld, r_mem_ld, r_wb_ld;

    logic [1:0]        r_sel_rs1;
    logic [1:0]        r_sel_rs2;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_ex_m1,  w_ex_m2;
    logic              w_mem_m1, w_mem_m2;
    logic              w_wb_m1,  w_wb_m2;
    logic              w_load_use;
    logic              w_issue;
    logic              w_cnt_inc;
    logic [1:0]        w_sel_rs1;
    logic [1:0]        w_sel_rs2;

    // x0 is hard-wired zero, so it never needs forwarding.
    function automatic logic f_match(input logic v, input logic wr,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic use_rs);
        return v && wr && (rd == rs) && (rs != '0) && use_rs;
    endfunction

    function automatic logic [1:0] f_sel(input logic m_ex, input logic m_mem,
                                         input logic m_wb);
        if (m_ex)       return c_SEL_EX;
        else if (m_mem) return c_SEL_MEM;
        else if (m_wb)  return c_SEL_WB;
        else            return c_SEL_RF;
    endfunction

    always_comb begin
        w_ex_m1    = f_match(r_ex_v,  r_ex_wr,  r_ex_rd,  id_rs1, id_use_rs1);
        w_ex_m2    = f_match(r_ex_v,  r_ex_wr,  r_ex_rd,  id_rs2, id_use_rs2);
        w_mem_m1   = f_match(r_mem_v, r_mem_wr, r_mem_rd, id_rs1, id_use_rs1);
        w_mem_m2   = f_match(r_mem_v, r_mem_wr, r_mem_rd, id_rs2, id_use_rs2);
        w_wb_m1    = f_match(r_wb_v,  r_wb_wr,  r_wb_rd,  id_rs1, id_use_rs1);
        w_wb_m2    = f_match(r_wb_v,  r_wb_wr,  r_wb_rd,  id_rs2, id_use_rs2);
        w_sel_rs1  = f_sel(w_ex_m1, w_mem_m1, w_wb_m1);
        w_sel_rs2  = f_sel(w_ex_m2, w_mem_m2, w_wb_m2);
        w_load_use = id_valid && r_ex_ld && (w_ex_m1 || w_ex_m2);
        w_issue    = id_valid && !flush && !w_load_use;
        w_cnt_inc  = !flush && w_load_use;
        stall_id   = mem_hold || w_cnt_inc;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_ex_v    <= 1'b0;
            r_ex_rd   <= '0;
            r_ex_wr   <= 1'b0;
            r_ex_ld   <= 1'b0;
            r_mem_v   <= 1'b0;
            r_mem_rd  <= '0;
            r_mem_wr  <= 1'b0;
            r_mem_ld  <= 1'b0;
            r_wb_v    <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_wr   <= 1'b0;
            r_wb_ld   <= 1'b0;
            r_sel_rs1 <= c_SEL_RF;
            r_sel_rs2 <= c_SEL_RF;
            r_cnt     <= '0;
        end else if (!mem_hold) begin
            r_mem_v  <= r_ex_v;
            r_mem_rd <= r_ex_rd;
            r_mem_wr <= r_ex_wr;
            r_mem_ld <= r_ex_ld;
            r_wb_v   <= r_mem_v;
            r_wb_rd  <= r_mem_rd;
            r_wb_wr  <= r_mem_wr;
            r_wb_ld  <= r_mem_ld;
            if (w_issue) begin
                r_ex_v    <= 1'b1;
                r_ex_rd   <= id_rd;
                r_ex_wr   <= id_wr_rd;
                r_ex_ld   <= id_is_load;
                r_sel_rs1 <= w_sel_rs1;
                r_sel_rs2 <= w_sel_rs2;
            end else begin
                r_ex_v    <= 1'b0;
                r_ex_rd   <= '0;
                r_ex_wr   <= 1'b0;
                r_ex_ld   <= 1'b0;
                r_sel_rs1 <= c_SEL_RF;
                r_sel_rs2 <= c_SEL_RF;
            end
            if (w_cnt_inc && (r_cnt != '1)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign ex_valid    = r_ex_v;
    assign fwd_sel_rs1 = r_sel_rs1;
    assign fwd_sel_rs2 = r_sel_rs2;
    assign bubble_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Scoreboard bench for hazard_forward_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_forward_ctrl;

    localparam int         CW      = 8;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       fl;
        logic       hd;
        logic       es;
        logic       ev;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       inc;
    } row_t;

    typedef logic [CW+4:0] obs_t;

    logic          clk_100MHz = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [4:0]    id_rd;
    logic          id_wr_rd;
    logic          id_is_load;
    logic          flush;
    logic          mem_hold;
    logic          stall_id;
    logic          ex_valid;
    logic [1:0]    fwd_sel_rs1;
    logic [1:0]    fwd_sel_rs2;
    logic [CW-1:0] bubble_cnt;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] exp_cnt = '0;
    obs_t          exp_q[$];

    always #5 clk_100MHz = ~clk_100MHz;

    hazard_forward_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_wr_rd   (id_wr_rd),
        .id_is_load (id_is_load),
        .flush      (flush),
        .mem_hold   (mem_hold),
        .stall_id   (stall_id),
        .ex_valid   (ex_valid),
        .fwd_sel_rs1(fwd_sel_rs1),
        .fwd_sel_rs2(fwd_sel_rs2),
        .bubble_cnt (bubble_cnt)
    );

    function automatic row_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic wr, input logic ld, input logic fl, input logic hd,
                                input logic es, input logic ev, input logic [1:0] s1,
                                input logic [1:0] s2, input logic inc);
        row_t r;
        r = '{v:v, rs1:rs1, rs2:rs2, u1:u1, u2:u2, rd:rd, wr:wr, ld:ld, fl:fl, hd:hd,
              es:es, ev:ev, s1:s1, s2:s2, inc:inc};
        return r;
    endfunction

    function automatic row_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    endfunction

    task automatic drive(input row_t r);
        id_valid   = r.v;
        id_rs1     = r.rs1;
        id_rs2     = r.rs2;
        id_use_rs1 = r.u1;
        id_use_rs2 = r.u2;
        id_rd      = r.rd;
        id_wr_rd   = r.wr;
        id_is_load = r.ld;
        flush      = r.fl;
        mem_hold   = r.hd;
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(idle());
        #12;
        n_tests++;
        if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt, stall_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ev=%b s1=%0d s2=%0d cnt=%0d stall=%b want all 0",
                     ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt, stall_id);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        obs_t want;
        repeat (3) rows.push_back(idle());
        rows.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        rows.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 1, 2'd1, 2'd1, 0));
        rows.push_back(mk(1, 5, 6, 1, 1, 7, 1, 0, 0, 0, 0, 1, 2'd2, 2'd1, 0));
        rows.push_back(mk(1, 5, 0, 1, 1, 8, 1, 0, 0, 0, 0, 1, 2'd3, 2'd0, 0));
        rows.push_back(idle());
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            #1;
            n_tests++;
            if (stall_id !== rows[i].es) begin
                n_fail++;
                $display("FAIL b2b[%0d] stall_id: got %b want %b", i, stall_id, rows[i].es);
            end
            exp_q.push_back({rows[i].ev, rows[i].s1, rows[i].s2, exp_cnt});
            tick();
            want = exp_q.pop_front();
            n_tests++;
            if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt} !== want) begin
                n_fail++;
                $display("FAIL b2b[%0d] {ev,s1,s2,cnt}: got %h want %h", i,
                         {ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt}, want);
            end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        obs_t want;
        repeat (3) rows.push_back(idle());
        rows.push_back(mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        rows.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 1));
        rows.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0));
        rows.push_back(idle());
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            #1;
            n_tests++;
            if (stall_id !== rows[i].es) begin
                n_fail++;
                $display("FAIL load_use[%0d] stall_id: got %b want %b", i, stall_id, rows[i].es);
            end
            if (rows[i].inc) exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1'b1;
            exp_q.push_back({rows[i].ev, rows[i].s1, rows[i].s2, exp_cnt});
            tick();
            want = exp_q.pop_front();
            n_tests++;
            if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt} !== want) begin
                n_fail++;
                $display("FAIL load_use[%0d] {ev,s1,s2,cnt}: got %h want %h", i,
                         {ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt}, want);
            end
        end
    endtask

    task automatic test_x0_unused();
        row_t rows[$];
        obs_t want;
        repeat (3) rows.push_back(idle());
        rows.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        rows.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        repeat (3) rows.push_back(idle());
        rows.push_back(mk(1, 2, 0, 1, 0, 3, 1, 1, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        rows.push_back(mk(1, 2, 3, 1, 0, 4, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        rows.push_back(idle());
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            #1;
            n_tests++;
            if (stall_id !== rows[i].es) begin
                n_fail++;
                $display("FAIL x0_unused[%0d] stall_id: got %b want %b", i, stall_id, rows[i].es);
            end
            exp_q.push_back({rows[i].ev, rows[i].s1, rows[i].s2, exp_cnt});
            tick();
            want = exp_q.pop_front();
            n_tests++;
            if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt} !== want) begin
                n_fail++;
                $display("FAIL x0_unused[%0d] {ev,s1,s2,cnt}: got %h want %h", i,
                         {ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt}, want);
            end
        end
    endtask

    task automatic test_flush();
        row_t rows[$];
        obs_t want;
        repeat (3) rows.push_back(idle());
        rows.push_back(mk(1, 2, 0, 1, 0, 3, 1, 1, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        rows.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0));
        rows.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0));
        rows.push_back(mk(1, 4, 4, 1, 1, 5, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0));
        rows.push_back(idle());
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            #1;
            n_tests++;
            if (stall_id !== rows[i].es) begin
                n_fail++;
                $display("FAIL flush[%0d] stall_id: got %b want %b", i, stall_id, rows[i].es);
            end
            exp_q.push_back({rows[i].ev, rows[i].s1, rows[i].s2, exp_cnt});
            tick();
            want = exp_q.pop_front();
            n_tests++;
            if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt} !== want) begin
                n_fail++;
                $display("FAIL flush[%0d] {ev,s1,s2,cnt}: got %h want %h", i,
                         {ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt}, want);
            end
        end
    endtask

    task automatic test_mem_hold();
        row_t rows[$];
        obs_t want;
        repeat (3) rows.push_back(idle());
        rows.push_back(mk(1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        rows.push_back(mk(1, 9, 0, 1, 0, 3, 1, 1, 0, 0, 0, 1, 2'd1, 2'd0, 0));
        repeat (4) rows.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 1, 1, 2'd1, 2'd0, 0));
        rows.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 1));
        rows.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0));
        rows.push_back(idle());
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            #1;
            n_tests++;
            if (stall_id !== rows[i].es) begin
                n_fail++;
                $display("FAIL mem_hold[%0d] stall_id: got %b want %b", i, stall_id, rows[i].es);
            end
            if (rows[i].inc) exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1'b1;
            exp_q.push_back({rows[i].ev, rows[i].s1, rows[i].s2, exp_cnt});
            tick();
            want = exp_q.pop_front();
            n_tests++;
            if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt} !== want) begin
                n_fail++;
                $display("FAIL mem_hold[%0d] {ev,s1,s2,cnt}: got %h want %h", i,
                         {ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt}, want);
            end
        end
    endtask

    task automatic test_reset_midstream();
        row_t rows[$];
        obs_t want;
        repeat (3) rows.push_back(idle());
        rows.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        rows.push_back(mk(1, 1, 2, 1, 1, 6, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        rows.push_back(mk(1, 5, 6, 1, 1, 7, 1, 0, 0, 0, 0, 1, 2'd2, 2'd1, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            #1;
            n_tests++;
            if (stall_id !== rows[i].es) begin
                n_fail++;
                $display("FAIL rst_mid[%0d] stall_id: got %b want %b", i, stall_id, rows[i].es);
            end
            exp_q.push_back({rows[i].ev, rows[i].s1, rows[i].s2, exp_cnt});
            tick();
            want = exp_q.pop_front();
            n_tests++;
            if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt} !== want) begin
                n_fail++;
                $display("FAIL rst_mid[%0d] {ev,s1,s2,cnt}: got %h want %h", i,
                         {ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt}, want);
            end
        end
        // Asynchronous assertion well away from any clock edge.
        drive(idle());
        reset = 1'b1;
        #2;
        exp_cnt = '0;
        n_tests++;
        if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got ev=%b s1=%0d s2=%0d cnt=%0d want all 0",
                     ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt);
        end
        reset = 1'b0;
        #1;
        drive(mk(1, 5, 6, 1, 1, 9, 1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        #1;
        exp_q.push_back({1'b1, 2'd0, 2'd0, exp_cnt});
        tick();
        want = exp_q.pop_front();
        n_tests++;
        if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt} !== want) begin
            n_fail++;
            $display("FAIL rst_mid_after {ev,s1,s2,cnt}: got %h want %h",
                     {ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt}, want);
        end
    endtask

    task automatic test_saturation();
        row_t rows[$];
        obs_t want;
        rows.push_back(idle());
        rows.push_back(mk(1, 3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 1, 2'd0, 2'd0, 0));
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            rows.push_back(mk(1, 3, 0, 1, 0, 3, 1, 1, 0, 0, 1, 0, 2'd0, 2'd0, 1));
            rows.push_back(mk(1, 3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 1, 2'd2, 2'd0, 0));
        end
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            #1;
            n_tests++;
            if (stall_id !== rows[i].es) begin
                n_fail++;
                $display("FAIL sat[%0d] stall_id: got %b want %b", i, stall_id, rows[i].es);
            end
            if (rows[i].inc) exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1'b1;
            exp_q.push_back({rows[i].ev, rows[i].s1, rows[i].s2, exp_cnt});
            tick();
            want = exp_q.pop_front();
            n_tests++;
            if ({ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt} !== want) begin
                n_fail++;
                $display("FAIL sat[%0d] {ev,s1,s2,cnt}: got %h want %h", i,
                         {ex_valid, fwd_sel_rs1, fwd_sel_rs2, bubble_cnt}, want);
            end
        end
        drive(idle());
        n_tests++;
        if (bubble_cnt !== CNT_MAX) begin
            n_fail++;
            $display("FAIL sat_final bubble_cnt: got %h want %h", bubble_cnt, CNT_MAX);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0_unused();
        test_flush();
        test_mem_hold();
        test_reset_midstream();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline hazard controller for the RV32I core.
- Keeps a 3-slot scoreboard of in-flight destination registers for the EX, MEM and WB stages.
- Generates registered operand-forwarding selects for the execute stage, a load-use stall/bubble, and a saturating bubble counter.
- Sits beside the decode/execute boundary. The decode stage issues into it; execute consumes the forward selects.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, bubble counter width.

Ports:
- clk_100MHz  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  decode stage holds a valid instruction.
- id_rs1  input  REG_AW  source register 1 of the ID instruction.
- id_rs2  input  REG_AW  source register 2 of the ID instruction.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2 (R_TYPE, STORE, branch).
- id_rd  input  REG_AW  destination of the ID instruction.
- id_wr_rd  input  1  ID instruction writes rd.
- id_is_load  input  1  ID instruction is a LOAD.
- flush  input  1  kill the ID instruction (taken branch or jump resolved in EX).
- mem_hold  input  1  memory stage busy; freeze the whole pipeline.
- stall_id  output  1  combinational; hold fetch/decode this cycle.
- ex_valid  output  1  registered; the instruction now in EX is real (0 = bubble).
- fwd_sel_rs1  output  2  registered; EX operand-1 source.
- fwd_sel_rs2  output  2  registered; EX operand-2 source.
- bubble_cnt  output  CNT_W  saturating count of inserted load-use bubbles.

Behaviour:
- Scoreboard slots EX/MEM/WB. Each slot holds {valid, rd, wr, is_load}.
- Reset (async, any time, including mid-stall): all slots invalid, ex_valid=0, fwd_sel_rs1=fwd_sel_rs2=0, bubble_cnt=0. First active edge after reset deassert behaves as normal.
- Forward select encoding: 0=register file, 1=EX/MEM result (data_out_exe), 2=MEM/WB register, 3=WB write-back bypass.
- Match rule: a slot matches source rs when slot.valid && slot.wr && slot.rd==rs && rs!=0 && use_rs. Register x0 never matches.
- Select priority at issue: match EX slot -> 1, else MEM slot -> 2, else WB slot -> 3, else 0. The youngest producer wins.
- Load-use hazard: the EX slot valid with is_load, and it matches rs1 or rs2 of a valid ID instruction.
- Per-cycle priority is mem_hold > flush > load-use > issue.
- mem_hold=1:
  - stall_id=1.
  - All slots, ex_valid, fwd_sel_* and bubble_cnt hold.
  - No hazard is evaluated.
- flush=1 (mem_hold=0):
  - stall_id=0.
  - The ID instruction is discarded. A bubble enters EX: EX slot invalid, ex_valid=0, fwd_sel_*=0.
  - MEM<-EX and WB<-MEM shift normally.
  - bubble_cnt does not increment, even if a load-use hazard coexists.
- Load-use hazard (no hold, no flush):
  - stall_id=1.
  - A bubble enters EX as in the flush case; MEM/WB shift.
  - bubble_cnt increments, saturating at all-ones.
  - Next cycle the load sits in the MEM slot, so a reissue selects 2.
- Normal issue (id_valid=1, no hazard):
  - The EX slot loads {1, id_rd, id_wr_rd, id_is_load}.
  - ex_valid=1. fwd_sel_* are computed against the pre-edge slots.
  - MEM/WB shift.
- id_valid=0: a bubble enters EX, stall_id=0, no count.
- Latency: fwd_sel_* and ex_valid appear one cycle after issue, aligned with the instruction in EX.
- stall_id is a pure function of the current inputs and slots. There is no path from it back into the inputs.
- The WB slot drops out after one cycle; the register file then holds the value.

Test Plan:
- Reset mid-stream: assert reset asynchronously between edges with 3 slots valid -> ex_valid=0, fwd_sel_*=0 and bubble_cnt=0 immediately, before the next edge.
- Back-to-back ALU chain:
  - Stimulus: ADD x5 issued, then SUB x6,x5,x5 next cycle, then OR x7,x5,x6, then AND x8,x5,x0.
  - Required: SUB in EX has fwd_sel_rs1=fwd_sel_rs2=1.
  - Required: OR in EX has rs1=2, rs2=1.
  - Required: AND in EX has rs1=3, rs2=0.
- Load-use:
  - Stimulus: LW x3 issued, then ADD x4,x3,x1 in ID.
  - Required: stall_id=1 for exactly 1 cycle; ex_valid=0 that cycle.
  - Required: ADD then enters EX with fwd_sel_rs1=2, fwd_sel_rs2=0; bubble_cnt=1.
- x0 and unused sources:
  - Stimulus: LW x0, then ADD x1,x0,x0.
  - Required: no stall, fwd_sel=0.
  - Stimulus: LW x3, then an I_TYPE instruction with id_use_rs2=0 and rs2 field=3.
  - Required: no stall.
- Simultaneous events:
  - Stimulus: load-use hazard with flush=1 -> stall_id=0, bubble, bubble_cnt unchanged.
  - Stimulus: hazard with mem_hold=1 for 4 cycles -> all registered outputs frozen. Hazard resolves with a single bubble after the hold releases.
- Counter saturation: force 2^16+3 load-use stalls -> bubble_cnt stays at 16'hFFFF with no wrap.
